// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: filters the shared PS/2 lines, drives them open-drain
// to send one command byte with odd parity, then checks the device acknowledge or times out.
module ps2_host_tx #(
   parameter int CLK_FREQ   = 28_000_000,
   parameter int INHIBIT_US = 100,
   parameter int START_US   = 5,
   parameter int TIMEOUT_MS = 15,
   parameter int FILTER     = 8
) (
   input  logic       clk28,
   input  logic       rst_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       rx_inhibit,
   output logic       done,
   output logic       error
);
   localparam int N_INH = (CLK_FREQ / 1_000_000) * INHIBIT_US;
   localparam int N_ST  = (CLK_FREQ / 1_000_000) * START_US;
   localparam int N_TO  = (CLK_FREQ / 1_000) * TIMEOUT_MS;
   localparam int W_INH = (N_INH > 1) ? $clog2(N_INH) : 1;
   localparam int W_ST  = (N_ST > 1) ? $clog2(N_ST) : 1;
   localparam int W_TO  = (N_TO > 1) ? $clog2(N_TO) : 1;
   localparam int W_FLT = (FILTER > 1) ? $clog2(FILTER) : 1;

   localparam logic [W_INH-1:0] INH_LAST = W_INH'(N_INH - 1);
   localparam logic [W_ST-1:0]  ST_LAST  = W_ST'(N_ST - 1);
   localparam logic [W_TO-1:0]  TO_LAST  = W_TO'(N_TO - 1);
   localparam logic [W_FLT-1:0] FLT_LAST = W_FLT'(FILTER - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_SHIFT     = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   logic [1:0]       r_sync1, r_sync2, r_filt;
   logic [W_FLT-1:0] r_fcnt [2];
   logic             r_clk_f_d;
   logic             w_clk_f, w_dat_f, w_fall;

   assign w_clk_f = r_filt[0];
   assign w_dat_f = r_filt[1];
   assign w_fall  = r_clk_f_d & ~r_filt[0];

   // Synchronize both pins and accept a new level only after FILTER stable samples (bit 0 clock, bit 1 data)
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 2'b11;
         r_sync2   <= 2'b11;
         r_filt    <= 2'b11;
         r_fcnt[0] <= '0;
         r_fcnt[1] <= '0;
         r_clk_f_d <= 1'b1;
      end else begin
         r_sync1   <= {ps2_dat_in, ps2_clk_in};
         r_sync2   <= r_sync1;
         r_clk_f_d <= r_filt[0];
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == FLT_LAST) begin
               r_filt[i] <= r_sync2[i];
               r_fcnt[i] <= '0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + W_FLT'(1);
            end
         end
      end
   end

   logic [2:0]       r_state;
   logic [W_INH-1:0] r_inh_cnt;
   logic [W_ST-1:0]  r_st_cnt;
   logic [W_TO-1:0]  r_to_cnt;
   logic [3:0]       r_n;
   logic [8:0]       r_frame;
   logic             r_ack_ok;
   logic             r_clk_oe, r_dat_oe, r_ready, r_busy, r_done, r_error;
   logic             w_timeout;

   assign w_timeout = (r_to_cnt == TO_LAST);

   // Transfer sequencer; ready/busy lag the return to IDLE by one cycle so they follow the done/error pulse
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_inh_cnt <= '0;
         r_st_cnt  <= '0;
         r_to_cnt  <= '0;
         r_n       <= 4'd0;
         r_frame   <= 9'd0;
         r_ack_ok  <= 1'b0;
         r_clk_oe  <= 1'b0;
         r_dat_oe  <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b0;
               if (tx_valid && r_ready) begin
                  r_frame   <= {odd_parity(tx_data), tx_data};
                  r_inh_cnt <= '0;
                  r_clk_oe  <= 1'b1;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_INHIBIT;
               end else begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_INHIBIT: begin
               if (r_inh_cnt == INH_LAST) begin
                  r_st_cnt <= '0;
                  r_dat_oe <= 1'b1;
                  r_state  <= S_START;
               end else begin
                  r_inh_cnt <= r_inh_cnt + W_INH'(1);
               end
            end
            S_START: begin
               if (r_st_cnt == ST_LAST) begin
                  r_clk_oe <= 1'b0;
                  r_n      <= 4'd0;
                  r_to_cnt <= '0;
                  r_state  <= S_SHIFT;
               end else begin
                  r_st_cnt <= r_st_cnt + W_ST'(1);
               end
            end
            S_SHIFT: begin
               if (w_timeout) begin
                  r_clk_oe <= 1'b0;
                  r_dat_oe <= 1'b0;
                  r_error  <= 1'b1;
                  r_state  <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + W_TO'(1);
                  if (w_fall) begin
                     r_n <= r_n + 4'd1;
                     // r_n still holds the previous count, so it indexes data[n-1] or the parity bit
                     if (r_n == 4'd9) begin
                        r_dat_oe <= 1'b0;
                        r_state  <= S_ACK;
                     end else begin
                        r_dat_oe <= ~r_frame[r_n];
                     end
                  end
               end
            end
            S_ACK: begin
               if (w_timeout) begin
                  r_clk_oe <= 1'b0;
                  r_dat_oe <= 1'b0;
                  r_error  <= 1'b1;
                  r_state  <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + W_TO'(1);
                  if (w_fall) begin
                     r_ack_ok <= ~w_dat_f;
                     r_error  <= w_dat_f;
                     r_state  <= S_WAIT_IDLE;
                  end
               end
            end
            S_WAIT_IDLE: begin
               if (w_clk_f && w_dat_f) begin
                  r_done  <= r_ack_ok;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;
   assign tx_ready   = r_ready;
   assign busy       = r_busy;
   assign rx_inhibit = r_busy;
   assign done       = r_done;
   assign error      = r_error;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: an open-drain PS/2 device model clocks the frame out,
// expected frames/outcomes are queued at accept time and a monitor compares on done/error.
module tb_ps2_host_tx;
   localparam int CLK_FREQ   = 1_000_000;
   localparam int INHIBIT_US = 100;
   localparam int START_US   = 5;
   localparam int TIMEOUT_MS = 15;
   localparam int FILTER     = 8;
   localparam int N_INH = (CLK_FREQ / 1_000_000) * INHIBIT_US;
   localparam int N_ST  = (CLK_FREQ / 1_000_000) * START_US;
   localparam int N_TO  = (CLK_FREQ / 1_000) * TIMEOUT_MS;
   localparam int HALF  = 20;

   // outcome kinds: 0 acknowledged, 1 no acknowledge, 2 device never clocks
   typedef struct {
      logic [10:0] frame;
      int          kind;
   } exp_t;

   logic        clk28 = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        dev_clk_low = 1'b0;
   logic        dev_dat_low = 1'b0;
   logic        glitch_low = 1'b0;
   logic        ps2_clk_in, ps2_dat_in;
   logic        ps2_clk_oe, ps2_dat_oe, tx_ready, busy, rx_inhibit, done, error;

   exp_t        exp_q[$];
   logic [10:0] dev_frame = 11'd0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          t_acc = 0;
   int          t_clk_rise = 0;
   int          t_start_end = 0;

   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .CLK_FREQ(CLK_FREQ), .INHIBIT_US(INHIBIT_US), .START_US(START_US),
      .TIMEOUT_MS(TIMEOUT_MS), .FILTER(FILTER)
   ) dut (
      .clk28(clk28), .rst_n(rst_n), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .rx_inhibit(rx_inhibit), .done(done), .error(error)
   );

   initial forever #5 clk28 = ~clk28;
   initial forever begin
      @(posedge clk28);
      cyc++;
   end

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
      end
   endtask

   // Line levels a device sees in time order: start, data LSB first, odd parity, stop
   function automatic logic [10:0] ref_frame(input logic [7:0] b);
      logic [10:0] f;
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic dev_run(input bit ack, input bit glitch, input int abort, output bit ok);
      int t = 0;
      logic [10:0] fr = 11'd0;
      ok = 1'b0;
      while (ps2_clk_oe !== 1'b1 && t < 4000) begin @(negedge clk28); t++; end
      while (ps2_clk_oe !== 1'b0 && t < 4000) begin @(negedge clk28); t++; end
      if (t >= 4000) return;
      ok = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (abort > 0 && i == abort) return;
         if (glitch) begin
            repeat (6) @(negedge clk28);
            glitch_low = 1'b1;
            repeat (4) @(negedge clk28);
            glitch_low = 1'b0;
            repeat (HALF - 10) @(negedge clk28);
         end else begin
            repeat (HALF) @(negedge clk28);
         end
         fr[i] = ps2_dat_in;
         if (i == 10) begin
            dev_frame = fr;
            if (ack) begin
               dev_dat_low = 1'b1;
               repeat (2) @(negedge clk28);
            end
         end
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk28);
         dev_clk_low = 1'b0;
      end
      dev_dat_low = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int kind, input bit glitch, input int abort,
                       input bit hold_junk);
      bit   ok;
      int   t = 0;
      exp_t e;
      @(negedge clk28);
      while (tx_ready !== 1'b1 && t < 40000) begin @(negedge clk28); t++; end
      check("ready_before_send", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      t_acc    = cyc;
      if (abort == 0) begin
         e.frame = ref_frame(b);
         e.kind  = kind;
         exp_q.push_back(e);
      end
      @(negedge clk28);
      if (hold_junk) tx_data = 8'h55;
      else tx_valid = 1'b0;
      if (kind != 2) begin
         dev_run(kind == 0, glitch, abort, ok);
         check("device_saw_release", ok, 1);
      end
      tx_valid = 1'b0;
      if (abort == 0) begin
         t = 0;
         while (exp_q.size() != 0 && t < 40000) begin @(negedge clk28); t++; end
         check("response_within_bound", exp_q.size(), 0);
      end
   endtask

   // Monitor: timing of the bus enables, flag consistency and scoreboard compare on each pulse
   initial begin
      exp_t e;
      logic p_clk_oe = 1'b0;
      logic p_dat_oe = 1'b0;
      bit   chk_ready = 1'b0;
      forever begin
         @(negedge clk28);
         if (rst_n) begin
            check("rx_inhibit_eq_busy", rx_inhibit, busy);
            check("ready_eq_not_busy", tx_ready, !busy);
            if (chk_ready) begin
               check("ready_after_pulse", tx_ready, 1);
               chk_ready = 1'b0;
            end
            if (ps2_clk_oe && !p_clk_oe) begin
               t_clk_rise = cyc;
               check("clk_oe_rise_latency", cyc - t_acc, 1);
            end
            if (ps2_dat_oe && !p_dat_oe && ps2_clk_oe)
               check("dat_oe_rise_offset", cyc - t_clk_rise, N_INH);
            if (!ps2_clk_oe && p_clk_oe) begin
               t_start_end = cyc;
               check("clk_oe_high_len", cyc - t_clk_rise, N_INH + N_ST);
            end
            if (done || error) begin
               check("done_error_exclusive", done & error, 0);
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_pulse", done, e.kind == 0);
                  check("error_pulse", error, e.kind != 0);
                  if (e.kind != 2) begin
                     check("device_frame", dev_frame, e.frame);
                  end else begin
                     check("timeout_delay", cyc - t_start_end, N_TO);
                     check("timeout_clk_oe", ps2_clk_oe, 0);
                     check("timeout_dat_oe", ps2_dat_oe, 0);
                  end
                  if (e.kind != 1) chk_ready = 1'b1;
               end
            end
         end
         p_clk_oe = ps2_clk_oe;
         p_dat_oe = ps2_dat_oe;
      end
   end

   initial begin
      #3_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(negedge clk28);
      rst_n = 1'b1;
      @(negedge clk28);
      check("reset_clk_oe", ps2_clk_oe, 0);
      check("reset_dat_oe", ps2_dat_oe, 0);
      check("reset_tx_ready", tx_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_rx_inhibit", rx_inhibit, 0);
      check("reset_done", done, 0);
      check("reset_error", error, 0);

      send(8'hED, 0, 1'b0, 0, 1'b0);
      send(8'h03, 0, 1'b0, 0, 1'b1);
      send(8'h07, 0, 1'b0, 0, 1'b0);
      send(8'h5A, 1, 1'b0, 0, 1'b0);
      repeat (40) @(negedge clk28);
      check("idle_after_nack", tx_ready, 1);
      send(8'h3C, 2, 1'b0, 0, 1'b0);
      send(8'hED, 0, 1'b1, 0, 1'b0);

      send(8'hA5, 0, 1'b0, 4, 1'b0);
      check("pre_reset_busy", busy, 1);
      check("pre_reset_dat_oe", ps2_dat_oe, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_clk_oe", ps2_clk_oe, 0);
      check("async_reset_dat_oe", ps2_dat_oe, 0);
      repeat (3) @(negedge clk28);
      rst_n = 1'b1;
      repeat (40) @(negedge clk28);
      check("post_reset_ready", tx_ready, 1);
      send(8'hFF, 0, 1'b0, 0, 1'b0);

      for (int k = 0; k < 4; k++) begin
         send(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0, 1'b0);
         repeat (30) @(negedge clk28);
      end

      repeat (50) @(negedge clk28);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
